// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and helpers: buffered entry layout, PC step and
// PC-relative branch target arithmetic.
package fetch_pkg;

   localparam int PC_INCR = 4;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // imm26 for unconditional B, imm19 for CBZ/B.cond; word offset scaled to bytes.
   function automatic logic [63:0] branch_target(input logic [63:0] pc,
                                                 input logic [31:0] instr,
                                                 input logic        uncond);
      logic [63:0] offset;
      if (uncond) offset = {{36{instr[25]}}, instr[25:0], 2'b00};
      else        offset = {{43{instr[23]}}, instr[23:5], 2'b00};
      return pc + offset;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is presented straight from registered storage.
module fetch_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  T                           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output T                           head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T              mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   // Pop on empty is dropped; a push into a full FIFO only lands alongside a pop.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC register, redirect mux, credit-limited issue to a
// fixed-latency imem, and a FIFO of {pc, instr} handed to decode.
module fetch_queue_unit #(
   parameter int                ADDR_W   = 64,
   parameter int                INSTR_W  = 32,
   parameter int                DEPTH    = 4,
   parameter int                IMEM_LAT = 1,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall_i,
   input  logic                       restore_i,
   input  logic [ADDR_W-1:0]          restore_pc_i,
   input  logic                       reg_jump_i,
   input  logic [ADDR_W-1:0]          reg_jump_pc_i,
   input  logic                       br_taken_i,
   input  logic                       br_uncond_i,
   input  logic [ADDR_W-1:0]          br_pc_i,
   input  logic [INSTR_W-1:0]         br_instr_i,
   output logic                       imem_req_o,
   output logic [ADDR_W-1:0]          imem_addr_o,
   input  logic [INSTR_W-1:0]         imem_instr_i,
   output logic                       dec_valid_o,
   input  logic                       dec_ready_i,
   output logic [INSTR_W-1:0]         dec_instr_o,
   output logic [ADDR_W-1:0]          dec_pc_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   import fetch_pkg::*;

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(IMEM_LAT+1);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   target;
   logic                redirect;
   logic                issue;
   logic [IMEM_LAT-1:0] pipe_vld;
   logic [ADDR_W-1:0]   pipe_pc [IMEM_LAT];
   logic [IW-1:0]       inflight;
   logic [CW-1:0]       count;
   logic                push;
   entry_t              push_data;
   entry_t              head;

   assign redirect = restore_i || reg_jump_i || br_taken_i;

   always_comb begin
      if (restore_i)       target = restore_pc_i;
      else if (reg_jump_i) target = reg_jump_pc_i;
      else                 target = ADDR_W'(branch_target(64'(br_pc_i), br_instr_i, br_uncond_i));
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < IMEM_LAT; i++) inflight = inflight + IW'(pipe_vld[i]);
   end

   // Every in-flight response owns a reserved FIFO slot, so pushes never overflow.
   assign issue = reset && !stall_i && !redirect
                  && ((int'(count) + int'(inflight)) < DEPTH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc       <= RESET_PC;
         pipe_vld <= '0;
         for (int i = 0; i < IMEM_LAT; i++) pipe_pc[i] <= '0;
      end else begin
         if (redirect)   pc <= target;
         else if (issue) pc <= pc + ADDR_W'(PC_INCR);
         pipe_vld[0] <= issue;
         pipe_pc[0]  <= pc;
         for (int i = 1; i < IMEM_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1] && !redirect;
            pipe_pc[i]  <= pipe_pc[i-1];
         end
      end
   end

   assign push            = pipe_vld[IMEM_LAT-1] && !redirect;
   assign push_data.pc    = pipe_pc[IMEM_LAT-1];
   assign push_data.instr = imem_instr_i;

   // Decode handshake: the head transfers on any edge where dec_valid_o && dec_ready_i;
   // dec_valid_o never depends on dec_ready_i, and the head is held until taken.
   fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (dec_ready_i),
      .flush     (redirect),
      .head      (head),
      .count     (count)
   );

   assign imem_req_o  = issue;
   assign imem_addr_o = pc;
   assign dec_valid_o = (count != '0);
   assign dec_instr_o = head.instr;
   assign dec_pc_o    = head.pc;
   assign count_o     = count;

endmodule
